bicubic_pass_scheduler: RTL and testbench
=========================================

BICUBIC_PASS_SCHEDULER -- requirements
Module: bicubic_pass_scheduler

Interface
REQ-001 Parameter PRODUCT_WIDTH, default 32: width of one pixel/product operand on the datapath port (sign-magnitude, MSB = sign in pass 2).
REQ-002 Parameter SCALE_SHIFT, default 14: right-shift applied to the final inner-product magnitude before clamping.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 s_valid  input  1  input window valid.
REQ-006 s_ready  output  1  scheduler can accept a window.
REQ-007 s_window  input  128  4x4 window of 8-bit pixels; row r, column c at bits [(r*4+c)*8 +: 8].
REQ-008 s_phase_x, s_phase_y  input  2 each  horizontal/vertical sub-pixel phase (0..3).
REQ-009 dp_w1..dp_w4  output  4 each  weight codes driven to the weight-vector x pixel-matrix datapath.
REQ-010 dp_p  output  16*PRODUCT_WIDTH  pixel matrix to datapath; element r_c at [((r-1)*4+(c-1))*PRODUCT_WIDTH +: PRODUCT_WIDTH].
REQ-011 dp_ip1..dp_ip4  input  PRODUCT_WIDTH-1 each  inner-product magnitudes from datapath (combinational response to dp_w/dp_p).
REQ-012 dp_sign1..dp_sign4  input  1 each  inner-product signs (1 = negative).
REQ-013 m_valid  output  1  result pixel valid; m_ready  input  1  consumer accepts.
REQ-014 m_pixel  output  8  interpolated, clamped pixel.
REQ-015 m_clamped  output  1  result was saturated at 0 or 255 (qualified by m_valid).
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, HPASS, VPASS, OUT; one-hot or binary is implementer's choice.
REQ-018 s_ready = 1 in IDLE, and in OUT when m_ready = 1; 0 otherwise.
REQ-019 s_valid && s_ready captures window and both phases into registers and moves to HPASS next cycle.
REQ-020 HPASS (1 cycle): dp_w1..4 = WEIGHT_LUT[phase_x]; dp_p row r column c = zero-extended window pixel (r,c); at cycle end capture dp_ip1..4 / dp_sign1..4 into four intermediate registers; go to VPASS.
REQ-021 VPASS (1 cycle): dp_w1..4 = WEIGHT_LUT[phase_y]; dp_p row 1 column k = {sign_k, magnitude_k} of intermediate k; rows 2-4 = 0; at cycle end compute result from dp_ip1/dp_sign1; go to OUT.
REQ-022 Result rule: sign = 1 or magnitude = 0 -> m_pixel = 0, m_clamped = sign; else v = magnitude >> SCALE_SHIFT, v > 255 -> m_pixel = 255, m_clamped = 1; else m_pixel = v[7:0], m_clamped = 0.
REQ-023 OUT: m_valid = 1, m_pixel/m_clamped held stable until m_ready; m_ready && !s_valid -> IDLE; m_ready && s_valid -> capture new window, go to HPASS (back-to-back).
REQ-024 Latency: window accepted on cycle N -> m_valid on cycle N+3; sustained throughput one pixel per 3 cycles with m_ready held high.
REQ-025 Input changes on s_window/s_phase while not accepted have no effect; captured values alone drive the datapath.
REQ-026 In IDLE and OUT, dp_w* = 0 and dp_p = 0 (datapath quiescent).

Reset
REQ-027 rst asserted asynchronously forces IDLE, m_valid = 0, m_pixel = 0, m_clamped = 0, busy = 0, all capture and intermediate registers = 0, regardless of state; a partially processed window is discarded.
REQ-028 s_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-029 Shared package bicubic_pkg holds WEIGHT_LUT (4 phases x 4 weight codes), state encoding, and SCALE_SHIFT default.
REQ-030 One sub-module is natural: bicubic_result_clamp (sign/shift/saturate, combinational), instanced once; the datapath itself is external.

Verification
REQ-031 Flat window all 100, phases 0/0, m_ready = 1 -> m_valid exactly 3 cycles after accept, m_pixel = 100, m_clamped = 0.
REQ-032 Window with 255 centre and large neighbours forcing overshoot -> m_pixel = 255, m_clamped = 1; negative-result window -> m_pixel = 0, m_clamped = 1.
REQ-033 m_ready held 0 for 5 cycles in OUT -> m_pixel stable, s_ready = 0, window changes on s_window ignored; on m_ready = 1 result accepted once.
REQ-034 Back-to-back: s_valid and m_ready held 1 for 4 windows -> 4 results at cycles 3, 6, 9, 12 with no bubble beyond the 3-cycle cadence.
REQ-035 rst pulsed during VPASS -> next cycle IDLE, m_valid = 0, no result emitted for the in-flight window; next window produces a correct result.
REQ-036 Datapath stub scoreboard checks dp_w = WEIGHT_LUT[phase_x] in HPASS and WEIGHT_LUT[phase_y] with rows 2-4 zero in VPASS, for all 16 phase pairs.

Source files
------------

// File: rtl/bicubic_pass_scheduler_pkg.sv
// Shared types and constants for the two-pass bicubic scheduler.
package bicubic_pkg;

  localparam int unsigned PIX_W               = 8;
  localparam int unsigned NUM_TAPS            = 4;
  localparam int unsigned WCODE_W             = 4;
  localparam int unsigned PHASE_W             = 2;
  localparam int unsigned WINDOW_W            = NUM_TAPS * NUM_TAPS * PIX_W;
  localparam int unsigned SCALE_SHIFT_DEFAULT = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HPASS = 2'd1,
    ST_VPASS = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Four weight codes, element 0 drives dp_w1 (leftmost/topmost tap).
  typedef logic [NUM_TAPS-1:0][WCODE_W-1:0] wvec_t;

  typedef struct packed {
    logic [WINDOW_W-1:0] window;
    logic [PHASE_W-1:0]  phase_x;
    logic [PHASE_W-1:0]  phase_y;
  } window_req_t;

  // Weight codes understood by the external datapath (weights scaled by 128):
  // 0:0  1:128  2:111  3:72  4:29  5:-3  6:-8  7:-9
  // Each phase row sums to 128, so two passes scale by 2^14.
  localparam wvec_t WEIGHT_LUT [NUM_TAPS] = '{
    16'h0010,   // phase 0: {0, 128, 0, 0}
    16'h5427,   // phase 1: {-9, 111, 29, -3}
    16'h6336,   // phase 2: {-8, 72, 72, -8}
    16'h7245    // phase 3: {-3, 29, 111, -9}
  };

endpackage

// File: rtl/bicubic_pass_scheduler_if.sv
// Window input and pixel output handshakes of the scheduler.
interface bicubic_pass_scheduler_if;
  import bicubic_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [WINDOW_W-1:0] s_window;
  logic [PHASE_W-1:0]  s_phase_x;
  logic [PHASE_W-1:0]  s_phase_y;
  logic                m_valid;
  logic                m_ready;
  logic [PIX_W-1:0]    m_pixel;
  logic                m_clamped;

  // Environment side: supplies windows, consumes pixels.
  modport master (
    output s_valid, s_window, s_phase_x, s_phase_y, m_ready,
    input  s_ready, m_valid, m_pixel, m_clamped
  );

  // Scheduler side.
  modport slave (
    input  s_valid, s_window, s_phase_x, s_phase_y, m_ready,
    output s_ready, m_valid, m_pixel, m_clamped
  );
endinterface

// File: rtl/bicubic_pass_scheduler_result_clamp.sv
// Converts the final sign-magnitude inner product into an 8-bit pixel.
module bicubic_result_clamp
  import bicubic_pkg::*;
#(
  parameter int unsigned MAG_W       = 31,
  parameter int unsigned SCALE_SHIFT = SCALE_SHIFT_DEFAULT
) (
  input  logic [MAG_W-1:0] mag,
  input  logic             sign,
  output logic [PIX_W-1:0] pixel_c,
  output logic             clamped_c
);

  logic [MAG_W-1:0] shifted_c;

  // Negative or zero floors at 0; oversized magnitudes saturate at 255.
  always_comb begin
    shifted_c = mag >> SCALE_SHIFT;
    pixel_c   = '0;
    clamped_c = 1'b0;
    if (sign || (mag == '0)) begin
      clamped_c = sign;
    end else if (shifted_c > MAG_W'(255)) begin
      pixel_c   = PIX_W'(255);
      clamped_c = 1'b1;
    end else begin
      pixel_c   = shifted_c[PIX_W-1:0];
    end
  end

endmodule

// File: rtl/bicubic_pass_scheduler.sv
// Sequences horizontal then vertical passes of a 4x4 bicubic window through
// an external weight x pixel-matrix datapath and clamps the final result.
module bicubic_pass_scheduler
  import bicubic_pkg::*;
#(
  parameter int unsigned PRODUCT_WIDTH = 32,
  parameter int unsigned SCALE_SHIFT   = SCALE_SHIFT_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  bicubic_pass_scheduler_if.slave     bus,
  output logic [WCODE_W-1:0]          dp_w1,
  output logic [WCODE_W-1:0]          dp_w2,
  output logic [WCODE_W-1:0]          dp_w3,
  output logic [WCODE_W-1:0]          dp_w4,
  output logic [16*PRODUCT_WIDTH-1:0] dp_p,
  input  logic [PRODUCT_WIDTH-2:0]    dp_ip1,
  input  logic [PRODUCT_WIDTH-2:0]    dp_ip2,
  input  logic [PRODUCT_WIDTH-2:0]    dp_ip3,
  input  logic [PRODUCT_WIDTH-2:0]    dp_ip4,
  input  logic                        dp_sign1,
  input  logic                        dp_sign2,
  input  logic                        dp_sign3,
  input  logic                        dp_sign4,
  output logic                        busy
);

  localparam int unsigned MAG_W = PRODUCT_WIDTH - 1;

  state_e                         state_q, state_d;
  window_req_t                    req_q, req_d;
  logic [NUM_TAPS-1:0][MAG_W-1:0] mag_q, mag_d;
  logic [NUM_TAPS-1:0]            sign_q, sign_d;
  logic                           m_valid_q, m_valid_d;
  logic [PIX_W-1:0]               m_pixel_q, m_pixel_d;
  logic                           m_clamped_q, m_clamped_d;

  logic                           s_ready_c;
  logic                           accept_c;
  wvec_t                          dp_w_c;
  logic [PIX_W-1:0]               clamp_pixel_c;
  logic                           clamp_flag_c;

  assign accept_c = bus.s_valid && s_ready_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed H -> V -> OUT sequence, back-to-back from OUT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_HPASS;
      ST_HPASS: state_d = ST_VPASS;
      ST_VPASS: state_d = ST_OUT;
      ST_OUT:   if (bus.m_ready) state_d = accept_c ? ST_HPASS : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: input handshake and datapath operands (quiescent outside passes)
  always_comb begin
    s_ready_c = 1'b0;
    dp_w_c    = '0;
    dp_p      = '0;
    unique case (state_q)
      ST_IDLE: s_ready_c = 1'b1;
      ST_HPASS: begin
        dp_w_c = WEIGHT_LUT[req_q.phase_x];
        for (int i = 0; i < int'(NUM_TAPS * NUM_TAPS); i++) begin
          dp_p[i*PRODUCT_WIDTH +: PRODUCT_WIDTH] = PRODUCT_WIDTH'(req_q.window[i*PIX_W +: PIX_W]);
        end
      end
      ST_VPASS: begin
        dp_w_c = WEIGHT_LUT[req_q.phase_y];
        for (int k = 0; k < int'(NUM_TAPS); k++) begin
          dp_p[k*PRODUCT_WIDTH +: PRODUCT_WIDTH] = {sign_q[k], mag_q[k]};
        end
      end
      ST_OUT:  s_ready_c = bus.m_ready;
      default: s_ready_c = 1'b0;
    endcase
  end

  // Data register updates: capture, intermediate results, output pixel
  always_comb begin
    req_d       = req_q;
    mag_d       = mag_q;
    sign_d      = sign_q;
    m_valid_d   = m_valid_q;
    m_pixel_d   = m_pixel_q;
    m_clamped_d = m_clamped_q;
    if (accept_c) begin
      req_d = '{window: bus.s_window, phase_x: bus.s_phase_x, phase_y: bus.s_phase_y};
    end
    if (state_q == ST_HPASS) begin
      mag_d  = {dp_ip4, dp_ip3, dp_ip2, dp_ip1};
      sign_d = {dp_sign4, dp_sign3, dp_sign2, dp_sign1};
    end
    if (state_q == ST_VPASS) begin
      m_valid_d   = 1'b1;
      m_pixel_d   = clamp_pixel_c;
      m_clamped_d = clamp_flag_c;
    end else if ((state_q == ST_OUT) && bus.m_ready) begin
      m_valid_d   = 1'b0;
    end
  end

  // Data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      mag_q       <= '0;
      sign_q      <= '0;
      m_valid_q   <= 1'b0;
      m_pixel_q   <= '0;
      m_clamped_q <= 1'b0;
    end else begin
      req_q       <= req_d;
      mag_q       <= mag_d;
      sign_q      <= sign_d;
      m_valid_q   <= m_valid_d;
      m_pixel_q   <= m_pixel_d;
      m_clamped_q <= m_clamped_d;
    end
  end

  bicubic_result_clamp #(
    .MAG_W       (MAG_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_clamp (
    .mag       (dp_ip1),
    .sign      (dp_sign1),
    .pixel_c   (clamp_pixel_c),
    .clamped_c (clamp_flag_c)
  );

  assign bus.s_ready   = s_ready_c;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_pixel   = m_pixel_q;
  assign bus.m_clamped = m_clamped_q;
  assign busy          = (state_q != ST_IDLE);
  assign dp_w1         = dp_w_c[0];
  assign dp_w2         = dp_w_c[1];
  assign dp_w3         = dp_w_c[2];
  assign dp_w4         = dp_w_c[3];

endmodule

// File: tb/tb_bicubic_pass_scheduler.sv
// Directed bench for bicubic_pass_scheduler with a behavioural datapath stub.
module tb_bicubic_pass_scheduler;

  localparam int unsigned PW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bicubic_pass_scheduler_if bus();

  logic [3:0]       dp_w1, dp_w2, dp_w3, dp_w4;
  logic [16*PW-1:0] dp_p;
  logic [PW-2:0]    dp_ip1, dp_ip2, dp_ip3, dp_ip4;
  logic             dp_sign1, dp_sign2, dp_sign3, dp_sign4;
  logic             busy;

  int checks = 0;
  int errors = 0;

  bicubic_pass_scheduler #(.PRODUCT_WIDTH(PW), .SCALE_SHIFT(14)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .dp_w1(dp_w1), .dp_w2(dp_w2), .dp_w3(dp_w3), .dp_w4(dp_w4),
    .dp_p(dp_p),
    .dp_ip1(dp_ip1), .dp_ip2(dp_ip2), .dp_ip3(dp_ip3), .dp_ip4(dp_ip4),
    .dp_sign1(dp_sign1), .dp_sign2(dp_sign2), .dp_sign3(dp_sign3), .dp_sign4(dp_sign4),
    .busy(busy)
  );

  // Datapath stub: weight code meaning, sign-magnitude operands, row-wise dot products
  function automatic longint wval(input logic [3:0] code);
    case (code)
      4'd1: return 128;
      4'd2: return 111;
      4'd3: return 72;
      4'd4: return 29;
      4'd5: return -3;
      4'd6: return -8;
      4'd7: return -9;
      default: return 0;
    endcase
  endfunction

  function automatic longint sm_val(input logic [PW-1:0] v);
    longint m;
    m = longint'(v[PW-2:0]);
    return v[PW-1] ? -m : m;
  endfunction

  function automatic logic [PW-2:0] mag_of(input longint a);
    return (PW-1)'((a < 0) ? -a : a);
  endfunction

  longint acc [4];
  logic [3:0] wcode [4];
  assign wcode[0] = dp_w1;
  assign wcode[1] = dp_w2;
  assign wcode[2] = dp_w3;
  assign wcode[3] = dp_w4;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      acc[r] = 0;
      for (int c = 0; c < 4; c++) begin
        acc[r] = acc[r] + wval(wcode[c]) * sm_val(dp_p[(r*4+c)*PW +: PW]);
      end
    end
  end

  assign dp_ip1 = mag_of(acc[0]);
  assign dp_ip2 = mag_of(acc[1]);
  assign dp_ip3 = mag_of(acc[2]);
  assign dp_ip4 = mag_of(acc[3]);
  assign dp_sign1 = acc[0] < 0;
  assign dp_sign2 = acc[1] < 0;
  assign dp_sign3 = acc[2] < 0;
  assign dp_sign4 = acc[3] < 0;

  // Expected weight vector {w4,w3,w2,w1} per phase
  function automatic logic [15:0] exp_lut(input logic [1:0] ph);
    case (ph)
      2'd0: return 16'h0010;
      2'd1: return 16'h5427;
      2'd2: return 16'h6336;
      default: return 16'h7245;
    endcase
  endfunction

  function automatic logic [127:0] win_flat(input logic [7:0] v);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[i*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [127:0] win_set(input logic [127:0] base, input int r, input int c,
                                           input logic [7:0] v);
    logic [127:0] w;
    w = base;
    w[(r*4+c)*8 +: 8] = v;
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One window from idle with m_ready high; checks every pass and the result
  task automatic run_window(input string tag, input logic [127:0] w, input logic [1:0] px,
                            input logic [1:0] py, input logic [7:0] exp_pix, input logic exp_clamp);
    bus.s_valid = 1'b1; bus.s_window = w; bus.s_phase_x = px; bus.s_phase_y = py;
    bus.m_ready = 1'b1;
    #1 check({tag, ".s_ready"}, 64'(bus.s_ready), 64'd1);
    step();
    bus.s_valid = 1'b0; bus.s_window = ~w; bus.s_phase_x = ~px; bus.s_phase_y = ~py;
    #1;
    check({tag, ".h_w"}, 64'({dp_w4, dp_w3, dp_w2, dp_w1}), 64'(exp_lut(px)));
    check({tag, ".h_p11"}, 64'(dp_p[5*PW +: PW]), 64'(w[5*8 +: 8]));
    check({tag, ".h_busy"}, 64'(busy), 64'd1);
    step();
    check({tag, ".v_w"}, 64'({dp_w4, dp_w3, dp_w2, dp_w1}), 64'(exp_lut(py)));
    check({tag, ".v_rows234"}, 64'(|dp_p[16*PW-1:4*PW]), 64'd0);
    check({tag, ".v_mvalid"}, 64'(bus.m_valid), 64'd0);
    step();
    check({tag, ".o_mvalid"}, 64'(bus.m_valid), 64'd1);
    check({tag, ".o_pixel"}, 64'(bus.m_pixel), 64'(exp_pix));
    check({tag, ".o_clamped"}, 64'(bus.m_clamped), 64'(exp_clamp));
    check({tag, ".o_dp_w"}, 64'({dp_w4, dp_w3, dp_w2, dp_w1}), 64'd0);
    step();
    check({tag, ".done_mvalid"}, 64'(bus.m_valid), 64'd0);
    check({tag, ".done_busy"}, 64'(busy), 64'd0);
  endtask

  logic [127:0] w_tmp;
  logic [7:0]   b2b_vals [4];

  initial begin
    bus.s_valid = 1'b0; bus.s_window = '0; bus.s_phase_x = '0; bus.s_phase_y = '0;
    bus.m_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.m_valid", 64'(bus.m_valid), 64'd0);
    check("rst.m_pixel", 64'(bus.m_pixel), 64'd0);
    check("rst.m_clamped", 64'(bus.m_clamped), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.dp_p", 64'(|dp_p), 64'd0);
    rst = 1'b0;
    #1 check("rst.s_ready_after", 64'(bus.s_ready), 64'd1);

    // Main function across distinct windows
    run_window("flat100", win_flat(8'd100), 2'd0, 2'd0, 8'd100, 1'b0);
    run_window("centre255", win_set('0, 1, 1, 8'd255), 2'd0, 2'd0, 8'd255, 1'b0);
    w_tmp = win_set('0, 1, 1, 8'd255);
    w_tmp = win_set(w_tmp, 1, 2, 8'd255);
    w_tmp = win_set(w_tmp, 2, 1, 8'd255);
    w_tmp = win_set(w_tmp, 2, 2, 8'd255);
    run_window("overshoot", w_tmp, 2'd2, 2'd2, 8'd255, 1'b1);
    w_tmp = win_set('0, 1, 0, 8'd255);
    w_tmp = win_set(w_tmp, 1, 3, 8'd255);
    w_tmp = win_set(w_tmp, 2, 0, 8'd255);
    w_tmp = win_set(w_tmp, 2, 3, 8'd255);
    run_window("negative", w_tmp, 2'd2, 2'd2, 8'd0, 1'b1);
    run_window("zero", '0, 2'd1, 2'd3, 8'd0, 1'b0);
    w_tmp = win_set('0, 1, 0, 8'd10);
    w_tmp = win_set(w_tmp, 1, 1, 8'd20);
    w_tmp = win_set(w_tmp, 1, 2, 8'd30);
    w_tmp = win_set(w_tmp, 1, 3, 8'd40);
    run_window("gradient", w_tmp, 2'd2, 2'd0, 8'd25, 1'b0);

    // Weight vectors for all phase pairs
    for (int px = 0; px < 4; px++) begin
      for (int py = 0; py < 4; py++) begin
        run_window($sformatf("ph%0d%0d", px, py), win_flat(8'd100), 2'(px), 2'(py), 8'd100, 1'b0);
      end
    end

    // Consumer stall in OUT
    bus.s_valid = 1'b1; bus.s_window = win_set('0, 1, 1, 8'd37);
    bus.s_phase_x = 2'd0; bus.s_phase_y = 2'd0; bus.m_ready = 1'b0;
    step();
    bus.s_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1; bus.s_window = win_flat(8'd200);
      #1;
      check($sformatf("stall%0d.m_valid", i), 64'(bus.m_valid), 64'd1);
      check($sformatf("stall%0d.m_pixel", i), 64'(bus.m_pixel), 64'd37);
      check($sformatf("stall%0d.s_ready", i), 64'(bus.s_ready), 64'd0);
      step();
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    #1;
    check("stall.release_s_ready", 64'(bus.s_ready), 64'd1);
    check("stall.release_pixel", 64'(bus.m_pixel), 64'd37);
    step();
    check("stall.after_m_valid", 64'(bus.m_valid), 64'd0);
    check("stall.after_busy", 64'(busy), 64'd0);
    step();
    check("stall.once_m_valid", 64'(bus.m_valid), 64'd0);

    // Back-to-back windows at a 3-cycle cadence
    b2b_vals[0] = 8'd11; b2b_vals[1] = 8'd22; b2b_vals[2] = 8'd33; b2b_vals[3] = 8'd44;
    step();
    for (int t = 0; t < 14; t++) begin
      int idx;
      logic exp_v;
      idx = (t + 2) / 3;
      if (idx > 3) idx = 3;
      bus.s_valid = (t <= 9);
      bus.s_window = win_set('0, 1, 1, b2b_vals[idx]);
      bus.s_phase_x = 2'd0; bus.s_phase_y = 2'd0; bus.m_ready = 1'b1;
      #1;
      exp_v = (t > 0) && (t % 3 == 0) && (t <= 12);
      check($sformatf("b2b%0d.m_valid", t), 64'(bus.m_valid), 64'(exp_v));
      if (exp_v) check($sformatf("b2b%0d.m_pixel", t), 64'(bus.m_pixel), 64'(b2b_vals[t/3 - 1]));
      step();
    end
    bus.s_valid = 1'b0;

    // Reset in VPASS discards the in-flight window
    bus.s_valid = 1'b1; bus.s_window = win_set('0, 1, 1, 8'd99); bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("vrst.busy", 64'(busy), 64'd0);
    check("vrst.m_valid", 64'(bus.m_valid), 64'd0);
    check("vrst.s_ready", 64'(bus.s_ready), 64'd1);
    check("vrst.dp_w", 64'({dp_w4, dp_w3, dp_w2, dp_w1}), 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("vrst.quiet%0d", i), 64'(bus.m_valid), 64'd0);
      step();
    end
    run_window("post_rst", win_set('0, 1, 1, 8'd37), 2'd0, 2'd0, 8'd37, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
